// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage: ALU opcodes, RV32I
// opcode/funct3 values used by the redirect logic, forward selects and the
// EX/MEM register payload.
package ex_pkg;

  localparam int XLEN_C = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Everything the MEM stage consumes, captured as one register word.
  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] pc4;
    logic        mem_rw;
    logic [1:0]  wb_sel;
    logic        reg_wen;
    logic [4:0]  rs_w;
    logic [31:0] inst;
  } ex_mem_t;

  // Operand forward mux; code 3 falls back to the register file value.
  function automatic logic [31:0] fwd_mux(input logic [1:0] sel,
                                          input logic [31:0] rf,
                                          input logic [31:0] mem,
                                          input logic [31:0] wb);
    case (sel)
      FWD_MEM: fwd_mux = mem;
      FWD_WB:  fwd_mux = wb;
      default: fwd_mux = rf;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational RV32I ALU. Shift amount is b[4:0]; unused encodings give 0.
module alu
  import ex_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alu_sel,
  output logic [31:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  // Operation select; all arithmetic wraps at 32 bits.
  always_comb begin
    result = '0;
    case (alu_sel)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_SLL:   result = a << shamt;
      ALU_SLT:   result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:  result = {31'b0, a < b};
      ALU_XOR:   result = a ^ b;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch comparator, combinational
// redirect toward IF, and the EX/MEM pipeline register with stall/flush.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_ex_i,
  input  logic [31:0] rs1_ex_i,
  input  logic [31:0] rs2_ex_i,
  input  logic [31:0] imm_ex_i,
  input  logic [31:0] inst_ex_i,
  input  logic        ASel_ex_i,
  input  logic        BSel_ex_i,
  input  logic [3:0]  ALUSel_ex_i,
  input  logic        MemRW_ex_i,
  input  logic [1:0]  WBSel_ex_i,
  input  logic        RegWEn_ex_i,
  input  logic [4:0]  rsW_ex_i,
  input  logic [1:0]  fwdA_sel_i,
  input  logic [1:0]  fwdB_sel_i,
  input  logic [31:0] alu_fwd_i,
  input  logic [31:0] wb_fwd_i,
  input  logic        enable_i,
  input  logic        reset_i,
  output logic        taken_o,
  output logic [31:0] target_o,
  output logic [31:0] alu_mem_o,
  output logic [31:0] rs2_mem_o,
  output logic [31:0] pc4_mem_o,
  output logic        MemRW_mem_o,
  output logic [1:0]  WBSel_mem_o,
  output logic        RegWEn_mem_o,
  output logic [4:0]  rsW_mem_o,
  output logic [31:0] inst_mem_o
);

  logic [XLEN-1:0] op_a_fwd, op_b_fwd, alu_a, alu_b, alu_result;
  logic            eq, lt_s, lt_u;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  ex_mem_t         ex_mem_d, ex_mem_q;

  assign op_a_fwd = fwd_mux(fwdA_sel_i, rs1_ex_i, alu_fwd_i, wb_fwd_i);
  assign op_b_fwd = fwd_mux(fwdB_sel_i, rs2_ex_i, alu_fwd_i, wb_fwd_i);
  assign alu_a    = ASel_ex_i ? pc_ex_i  : op_a_fwd;
  assign alu_b    = BSel_ex_i ? imm_ex_i : op_b_fwd;

  alu u_alu (
    .a       (alu_a),
    .b       (alu_b),
    .alu_sel (ALUSel_ex_i),
    .result  (alu_result)
  );

  // Comparator sees the forwarded register values, not the ALU operands
  // (a branch's ALU computes pc + imm in parallel).
  assign eq   = (op_a_fwd == op_b_fwd);
  assign lt_s = ($signed(op_a_fwd) < $signed(op_b_fwd));
  assign lt_u = (op_a_fwd < op_b_fwd);

  assign opcode = inst_ex_i[6:0];
  assign funct3 = inst_ex_i[14:12];

  // Redirect decision; independent of stall/flush so IF sees it immediately.
  always_comb begin
    taken_o  = 1'b0;
    target_o = alu_result;
    case (opcode)
      OP_BRANCH: begin
        case (funct3)
          F3_BEQ:  taken_o = eq;
          F3_BNE:  taken_o = !eq;
          F3_BLT:  taken_o = lt_s;
          F3_BGE:  taken_o = !lt_s;
          F3_BLTU: taken_o = lt_u;
          F3_BGEU: taken_o = !lt_u;
          default: taken_o = 1'b0;
        endcase
      end
      OP_JAL:  taken_o = 1'b1;
      OP_JALR: begin
        taken_o  = 1'b1;
        target_o = {alu_result[31:1], 1'b0};
      end
      default: taken_o = 1'b0;
    endcase
  end

  // Next EX/MEM contents when the register loads.
  always_comb begin
    ex_mem_d         = '0;
    ex_mem_d.alu     = alu_result;
    ex_mem_d.rs2     = op_b_fwd;
    ex_mem_d.pc4     = pc_ex_i + 32'd4;
    ex_mem_d.mem_rw  = MemRW_ex_i;
    ex_mem_d.wb_sel  = WBSel_ex_i;
    ex_mem_d.reg_wen = RegWEn_ex_i;
    ex_mem_d.rs_w    = rsW_ex_i;
    ex_mem_d.inst    = inst_ex_i;
  end

  // EX/MEM register: reset beats stall, stall beats flush, flush beats load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_mem_q <= '0;
    end else if (enable_i) begin
      if (reset_i) ex_mem_q <= '0;
      else         ex_mem_q <= ex_mem_d;
    end
  end

  assign alu_mem_o    = ex_mem_q.alu;
  assign rs2_mem_o    = ex_mem_q.rs2;
  assign pc4_mem_o    = ex_mem_q.pc4;
  assign MemRW_mem_o  = ex_mem_q.mem_rw;
  assign WBSel_mem_o  = ex_mem_q.wb_sel;
  assign RegWEn_mem_o = ex_mem_q.reg_wen;
  assign rsW_mem_o    = ex_mem_q.rs_w;
  assign inst_mem_o   = ex_mem_q.inst;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU ops, branch/jump redirect,
// stall/flush/reset behaviour of the EX/MEM register.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, rs1, rs2, imm, inst;
  logic        asel, bsel;
  logic [3:0]  alusel;
  logic        memrw;
  logic [1:0]  wbsel;
  logic        regwen;
  logic [4:0]  rsw;
  logic [1:0]  fwda, fwdb;
  logic [31:0] alu_fwd, wb_fwd;
  logic        enable, flush;
  logic        taken;
  logic [31:0] target, alu_mem, rs2_mem, pc4_mem, inst_mem;
  logic        memrw_mem, regwen_mem;
  logic [1:0]  wbsel_mem;
  logic [4:0]  rsw_mem;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk_i(clk), .rst_i(rst), .pc_ex_i(pc), .rs1_ex_i(rs1), .rs2_ex_i(rs2),
    .imm_ex_i(imm), .inst_ex_i(inst), .ASel_ex_i(asel), .BSel_ex_i(bsel),
    .ALUSel_ex_i(alusel), .MemRW_ex_i(memrw), .WBSel_ex_i(wbsel),
    .RegWEn_ex_i(regwen), .rsW_ex_i(rsw), .fwdA_sel_i(fwda), .fwdB_sel_i(fwdb),
    .alu_fwd_i(alu_fwd), .wb_fwd_i(wb_fwd), .enable_i(enable), .reset_i(flush),
    .taken_o(taken), .target_o(target), .alu_mem_o(alu_mem), .rs2_mem_o(rs2_mem),
    .pc4_mem_o(pc4_mem), .MemRW_mem_o(memrw_mem), .WBSel_mem_o(wbsel_mem),
    .RegWEn_mem_o(regwen_mem), .rsW_mem_o(rsw_mem), .inst_mem_o(inst_mem)
  );

  task automatic defaults();
    rst = 0; pc = 0; rs1 = 0; rs2 = 0; imm = 0; inst = 0;
    asel = 0; bsel = 0; alusel = 0; memrw = 0; wbsel = 0; regwen = 0; rsw = 0;
    fwda = 0; fwdb = 0; alu_fwd = 0; wb_fwd = 0; enable = 1; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    defaults();
    rst = 1; rs1 = 32'h55; rs2 = 32'h66; regwen = 1; memrw = 1; rsw = 5'd9;
    inst = 32'h33; pc = 32'h80;
    tick();
    rst = 0;
    total_cnt++;
    if ({alu_mem, rs2_mem, pc4_mem, inst_mem} !== 128'h0) $display("FAIL reset_data got %h %h %h %h exp 0", alu_mem, rs2_mem, pc4_mem, inst_mem);
    else pass_cnt++;
    total_cnt++;
    if ({memrw_mem, wbsel_mem, regwen_mem, rsw_mem} !== 9'h0) $display("FAIL reset_ctrl got %b%b%b%b exp 0", memrw_mem, wbsel_mem, regwen_mem, rsw_mem);
    else pass_cnt++;
  endtask

  task automatic test_add_fwd();
    defaults();
    rs1 = 5; alu_fwd = 7; fwda = 2'd1; fwdb = 2'd0; rs2 = 3; alusel = 4'd0;
    regwen = 1; rsw = 5'd5; wbsel = 2'd1; inst = 32'h00000033;
    #1;
    total_cnt++;
    if (taken !== 1'b0) $display("FAIL add_taken got %b exp 0", taken);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (alu_mem !== 32'd10 || rs2_mem !== 32'd3) $display("FAIL add_fwd got alu=%0d rs2=%0d exp 10 3", alu_mem, rs2_mem);
    else pass_cnt++;
    total_cnt++;
    if (regwen_mem !== 1'b1 || rsw_mem !== 5'd5 || wbsel_mem !== 2'd1 || inst_mem !== 32'h33) $display("FAIL add_ctrl got %b %0d %0d %h exp 1 5 1 33", regwen_mem, rsw_mem, wbsel_mem, inst_mem);
    else pass_cnt++;
    // WB forward on A, select 3 falls back to rs2 on B; store data follows B.
    wb_fwd = 100; fwda = 2'd2; fwdb = 2'd3; memrw = 1;
    tick();
    total_cnt++;
    if (alu_mem !== 32'd103 || rs2_mem !== 32'd3 || memrw_mem !== 1'b1) $display("FAIL wb_fwd got alu=%0d rs2=%0d mw=%b exp 103 3 1", alu_mem, rs2_mem, memrw_mem);
    else pass_cnt++;
  endtask

  task automatic test_stall_flush();
    defaults();
    rs1 = 9; rs2 = 4; alusel = 4'd1; regwen = 1; rsw = 5'd3; inst = 32'h40000033;
    tick();
    total_cnt++;
    if (alu_mem !== 32'd5) $display("FAIL sub_load got %0d exp 5", alu_mem);
    else pass_cnt++;
    enable = 0;
    for (int i = 0; i < 3; i++) begin
      rs1 = 100 + i; rs2 = 1; alusel = 4'd0; flush = (i == 1);
      tick();
      total_cnt++;
      if (alu_mem !== 32'd5 || regwen_mem !== 1'b1) $display("FAIL stall_hold%0d got %0d/%b exp 5/1", i, alu_mem, regwen_mem);
      else pass_cnt++;
    end
    enable = 1; flush = 1;
    tick();
    flush = 0;
    total_cnt++;
    if (alu_mem !== 0 || rs2_mem !== 0 || pc4_mem !== 0 || inst_mem !== 0 || regwen_mem !== 0 || memrw_mem !== 0 || rsw_mem !== 0) $display("FAIL flush_bubble got alu=%h pc4=%h inst=%h rw=%b exp all 0", alu_mem, pc4_mem, inst_mem, regwen_mem);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    defaults();
    pc = 32'h100; imm = 32'h20; rs1 = 32'hFFFFFFFF; rs2 = 32'd1;
    asel = 1; bsel = 1; alusel = 4'd0;
    inst = 32'h00004063; // BLT
    #1;
    total_cnt++;
    if (taken !== 1'b1 || target !== 32'h120) $display("FAIL blt got taken=%b tgt=%h exp 1 120", taken, target);
    else pass_cnt++;
    inst = 32'h00006063; // BLTU
    #1;
    total_cnt++;
    if (taken !== 1'b0) $display("FAIL bltu got %b exp 0", taken);
    else pass_cnt++;
    inst = 32'h00007063; // BGEU
    #1;
    total_cnt++;
    if (taken !== 1'b1) $display("FAIL bgeu got %b exp 1", taken);
    else pass_cnt++;
    inst = 32'h00000063; // BEQ, operands differ
    #1;
    total_cnt++;
    if (taken !== 1'b0) $display("FAIL beq got %b exp 0", taken);
    else pass_cnt++;
    inst = 32'h00002063; // funct3 010: never taken
    rs2 = 32'hFFFFFFFF;
    #1;
    total_cnt++;
    if (taken !== 1'b0) $display("FAIL f3_010 got %b exp 0", taken);
    else pass_cnt++;
    inst = 32'h00001063; // BNE, operands now equal
    #1;
    total_cnt++;
    if (taken !== 1'b0) $display("FAIL bne_eq got %b exp 0", taken);
    else pass_cnt++;
    // Stall/flush must not gate the redirect path.
    inst = 32'h0000006F; enable = 0; flush = 1; // JAL
    #1;
    total_cnt++;
    if (taken !== 1'b1 || target !== 32'h120) $display("FAIL jal got taken=%b tgt=%h exp 1 120", taken, target);
    else pass_cnt++;
    enable = 1; flush = 0;
  endtask

  task automatic test_jalr();
    defaults();
    rs1 = 32'h1001; imm = 32'd2; bsel = 1; alusel = 4'd0; pc = 32'h40;
    inst = 32'h00000067; regwen = 1; rsw = 5'd1; wbsel = 2'd2;
    #1;
    total_cnt++;
    if (taken !== 1'b1 || target !== 32'h1002) $display("FAIL jalr got taken=%b tgt=%h exp 1 1002", taken, target);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (pc4_mem !== 32'h44 || alu_mem !== 32'h1003) $display("FAIL jalr_mem got pc4=%h alu=%h exp 44 1003", pc4_mem, alu_mem);
    else pass_cnt++;
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops [7];
    logic [31:0] av  [7];
    logic [31:0] bv  [7];
    logic [31:0] exp [7];
    ops[0] = 4'd7;  av[0] = 32'h80000000; bv[0] = 32'h24; exp[0] = 32'hF8000000; // SRA
    ops[1] = 4'd6;  av[1] = 32'h80000000; bv[1] = 32'h24; exp[1] = 32'h08000000; // SRL
    ops[2] = 4'd3;  av[2] = 32'hFFFFFFFF; bv[2] = 32'd1;  exp[2] = 32'd1;        // SLT
    ops[3] = 4'd4;  av[3] = 32'hFFFFFFFF; bv[3] = 32'd1;  exp[3] = 32'd0;        // SLTU
    ops[4] = 4'd2;  av[4] = 32'h00000003; bv[4] = 32'h21; exp[4] = 32'h6;        // SLL by 1
    ops[5] = 4'd10; av[5] = 32'h12345678; bv[5] = 32'hABCD0000; exp[5] = 32'hABCD0000; // PASSB
    ops[6] = 4'd15; av[6] = 32'hFFFFFFFF; bv[6] = 32'hFFFFFFFF; exp[6] = 32'd0;  // unused
    for (int i = 0; i < 7; i++) begin
      defaults();
      rs1 = av[i]; rs2 = bv[i]; alusel = ops[i];
      tick();
      total_cnt++;
      if (alu_mem !== exp[i]) $display("FAIL alu_op%0d got %h exp %h", ops[i], alu_mem, exp[i]);
      else pass_cnt++;
    end
    // Logic ops and wrap-around add.
    defaults(); rs1 = 32'hF0F0F0F0; rs2 = 32'hFF00FF00; alusel = 4'd5;
    tick();
    total_cnt++;
    if (alu_mem !== 32'h0FF00FF0) $display("FAIL xor got %h exp 0ff00ff0", alu_mem);
    else pass_cnt++;
    alusel = 4'd8;
    tick();
    total_cnt++;
    if (alu_mem !== 32'hFFF0FFF0) $display("FAIL or got %h exp fff0fff0", alu_mem);
    else pass_cnt++;
    alusel = 4'd9;
    tick();
    total_cnt++;
    if (alu_mem !== 32'hF000F000) $display("FAIL and got %h exp f000f000", alu_mem);
    else pass_cnt++;
    rs1 = 32'hFFFFFFFF; rs2 = 32'd2; alusel = 4'd0;
    tick();
    total_cnt++;
    if (alu_mem !== 32'd1) $display("FAIL add_wrap got %h exp 1", alu_mem);
    else pass_cnt++;
  endtask

  task automatic test_pc_wrap();
    defaults();
    pc = 32'hFFFFFFFC;
    tick();
    total_cnt++;
    if (pc4_mem !== 32'h0) $display("FAIL pc4_wrap got %h exp 0", pc4_mem);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    defaults();
    rs1 = 32'h77; regwen = 1; memrw = 1; rsw = 5'd7; pc = 32'h200; inst = 32'h33;
    tick();
    total_cnt++;
    if (alu_mem !== 32'h77 || pc4_mem !== 32'h204) $display("FAIL pre_reset got alu=%h pc4=%h exp 77 204", alu_mem, pc4_mem);
    else pass_cnt++;
    enable = 0; flush = 0; rst = 1;
    tick();
    rst = 0; inst = 0;
    #1;
    total_cnt++;
    if (alu_mem !== 0 || pc4_mem !== 0 || regwen_mem !== 0 || memrw_mem !== 0 || rsw_mem !== 0 || inst_mem !== 0) $display("FAIL reset_mid got alu=%h pc4=%h rw=%b exp all 0", alu_mem, pc4_mem, regwen_mem);
    else pass_cnt++;
    total_cnt++;
    if (taken !== 1'b0) $display("FAIL bubble_taken got %b exp 0", taken);
    else pass_cnt++;
  endtask

  initial begin
    defaults();
    test_reset();
    test_add_fwd();
    test_stall_flush();
    test_branch();
    test_jalr();
    test_alu_ops();
    test_pc_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage stall-model RV32I pipeline. Sits between the ID/EX register and the MEM stage.
- Selects forwarded operands, runs the ALU and the branch comparator, and resolves branch/jump redirects combinationally toward IF.
- Registers all MEM-bound signals in the EX/MEM pipeline register, which supports hold (stall) and flush (bubble).

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- pc_ex_i  in  32  PC of the instruction in EX.
- rs1_ex_i  in  32  register-file read data for rs1.
- rs2_ex_i  in  32  register-file read data for rs2.
- imm_ex_i  in  32  sign-extended immediate.
- inst_ex_i  in  32  instruction word (0 = bubble).
- ASel_ex_i  in  1  ALU operand A select: 0 = rs1, 1 = pc.
- BSel_ex_i  in  1  ALU operand B select: 0 = rs2, 1 = imm.
- ALUSel_ex_i  in  4  ALU operation (encoding in package).
- MemRW_ex_i  in  1  store enable, passed through.
- WBSel_ex_i  in  2  write-back select, passed through.
- RegWEn_ex_i  in  1  register write enable, passed through.
- rsW_ex_i  in  5  destination register, passed through.
- fwdA_sel_i  in  2  rs1 forward select: 0 = rs1_ex_i, 1 = alu_fwd_i, 2 = wb_fwd_i, 3 = rs1_ex_i.
- fwdB_sel_i  in  2  rs2 forward select, same encoding.
- alu_fwd_i  in  32  EX/MEM ALU result, for forwarding.
- wb_fwd_i  in  32  write-back data, for forwarding.
- enable_i  in  1  EX/MEM register load enable; 0 = stall.
- reset_i  in  1  flush; inserts a bubble when enable_i = 1.
- taken_o  out  1  redirect request to IF (combinational).
- target_o  out  32  redirect target (combinational).
- alu_mem_o  out  32  registered ALU result.
- rs2_mem_o  out  32  registered forwarded rs2 (store data).
- pc4_mem_o  out  32  registered pc + 4.
- MemRW_mem_o  out  1  registered store enable.
- WBSel_mem_o  out  2  registered write-back select.
- RegWEn_mem_o  out  1  registered register write enable.
- rsW_mem_o  out  5  registered destination register.
- inst_mem_o  out  32  registered instruction word.

Behaviour:
- Operand forwarding:
  - opA_fwd = mux(fwdA_sel_i); opB_fwd = mux(fwdB_sel_i).
  - ALU A = ASel ? pc_ex_i : opA_fwd.
  - ALU B = BSel ? imm_ex_i : opB_fwd.
- ALU operations:
  - ADD, SUB, XOR, OR, AND.
  - SLL / SRL / SRA: shift amount is B[4:0]; SRA is arithmetic.
  - SLT is signed; SLTU is unsigned; both zero-extend a 1-bit result.
  - PASSB (LUI).
  - Unused encodings produce 0.
  - All arithmetic wraps modulo 2^32.
- Comparator:
  - Works on opA_fwd / opB_fwd, never on the ALU-muxed operands.
  - eq = (A == B); lt_s is signed compare; lt_u is unsigned compare.
- Redirect, decoded from inst_ex_i opcode and funct3:
  - BRANCH (1100011): BEQ eq, BNE !eq, BLT lt_s, BGE !lt_s, BLTU lt_u, BGEU !lt_u. funct3 010/011 = not taken.
  - JAL (1101111) and JALR (1100111): always taken.
  - Any other opcode, including bubble 0: taken_o = 0.
  - target_o = alu_result, with bit0 forced to 0 for JALR; otherwise unmodified.
- Combinational path: taken_o and target_o have zero latency and do not depend on enable_i or reset_i.
- EX/MEM register, evaluated on posedge clk_i, priority rst_i > !enable_i > reset_i > load:
  - rst_i = 1: every registered output becomes 0.
  - enable_i = 0: all registers hold their values; reset_i is ignored.
  - enable_i = 1, reset_i = 1: all registers become 0, giving a bubble with RegWEn = 0, MemRW = 0, inst = 0.
  - enable_i = 1, reset_i = 0: load alu_result, opB_fwd, pc_ex_i + 4, and the pass-through controls.
- Reset state: every registered output = 0.
- Latency: 1 cycle from EX inputs to *_mem_o.
- pc4 wraps: pc_ex_i = 32'hFFFFFFFC gives pc4_mem_o = 0.
- Reset asserted mid-stall: rst_i wins; the next cycle starts from all-zero.

Decomposition:
- Package ex_pkg:
  - alu_op_e, 4 bits: ADD = 0, SUB = 1, SLL = 2, SLT = 3, SLTU = 4, XOR = 5, SRL = 6, SRA = 7, OR = 8, AND = 9, PASSB = 10.
  - Opcode constants OP_BRANCH, OP_JAL, OP_JALR.
  - funct3 constants for branches.
  - Forward-select constants FWD_RF = 0, FWD_MEM = 1, FWD_WB = 2.
- Sub-module alu: purely combinational (a, b, ALUSel → result); reusable by other stages.
- The comparator, the redirect logic and the register all live in ex_stage.

Test Plan:
- ADD with forwarding: rs1_ex_i = 5, alu_fwd_i = 7, fwdA_sel = 1, fwdB_sel = 0, rs2_ex_i = 3, enable = 1 → next cycle alu_mem_o = 10, rs2_mem_o = 3.
- Stall then flush:
  - Load SUB 9 − 4 → alu_mem_o = 5.
  - Hold with enable = 0 for 3 cycles while changing inputs → alu_mem_o stays 5.
  - enable = 1, reset_i = 1 → all outputs 0, RegWEn_mem_o = 0.
- Signed vs unsigned branch: opA = 32'hFFFFFFFF, opB = 1, BLT (funct3 100) → taken_o = 1; BLTU (funct3 110) → taken_o = 0. target_o = pc_ex_i + imm with ASel = 1, BSel = 1, ADD.
- JALR: rs1 = 32'h1001, imm = 2 → target_o = 32'h1002, taken_o = 1; pc_ex_i = 32'h40 → pc4_mem_o = 32'h44.
- Shifts and compare: A = 32'h80000000, B = 32'h24 → SRA = 32'hF8000000, SRL = 32'h08000000 (shift amount 4); SLT(−1, 1) = 1; SLTU(−1, 1) = 0.
- Reset mid-operation: rst_i = 1 with enable = 0 and reset_i = 0 after a loaded state → all outputs 0 next edge; bubble inst = 0 gives taken_o = 0.
